// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of the two requester byte-command ports, the shared I2C master port and arbiter status.
// slave is the arbiter's view; master is the view of whatever drives the requesters and master.
interface i2c_bus_arbiter_if;
    logic       s0_req;
    logic [3:0] s0_cmd;
    logic [7:0] s0_wr_data;
    logic [7:0] s0_rd_data;
    logic       s0_done;
    logic       s1_req;
    logic [3:0] s1_cmd;
    logic [7:0] s1_wr_data;
    logic [7:0] s1_rd_data;
    logic       s1_done;
    logic       m_req;
    logic [3:0] m_cmd;
    logic [7:0] m_wr_data;
    logic [7:0] m_rd_data;
    logic       m_done;
    logic [1:0] gnt;
    logic       busy;
    logic       err_timeout;

    modport slave (
        input  s0_req, s0_cmd, s0_wr_data, s1_req, s1_cmd, s1_wr_data, m_rd_data, m_done,
        output s0_rd_data, s0_done, s1_rd_data, s1_done, m_req, m_cmd, m_wr_data,
        output gnt, busy, err_timeout
    );

    modport master (
        output s0_req, s0_cmd, s0_wr_data, s1_req, s1_cmd, s1_wr_data, m_rd_data, m_done,
        input  s0_rd_data, s0_done, s1_rd_data, s1_done, m_req, m_cmd, m_wr_data,
        input  gnt, busy, err_timeout
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master between two requesters.
// Ownership spans a whole transaction; a watchdog reclaims the bus from a silent owner.
module i2c_bus_arbiter #(
    parameter logic [3:0]  STOP_MASK    = 4'b1000,
    parameter logic [15:0] IDLE_TIMEOUT = 16'd50_000
) (
    input logic              clk,
    input logic              rst_n,
    i2c_bus_arbiter_if.slave bus
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLock0 = 2'b01,
        StLock1 = 2'b10
    } state_e;

    state_e      r_state, w_state_next;
    logic        r_last_owner, w_last_owner_next;
    logic [15:0] r_idle_cnt, w_idle_cnt_next;
    logic        r_err_timeout, w_err_timeout_next;

    logic        w_own_req;
    logic [3:0]  w_own_cmd;
    logic [7:0]  w_own_wr_data;
    logic        w_stop_done;
    logic        w_timeout;

    always_comb begin
        w_own_req     = 1'b0;
        w_own_cmd     = '0;
        w_own_wr_data = '0;
        case (r_state)
            StLock0: begin
                w_own_req     = bus.s0_req;
                w_own_cmd     = bus.s0_cmd;
                w_own_wr_data = bus.s0_wr_data;
            end
            StLock1: begin
                w_own_req     = bus.s1_req;
                w_own_cmd     = bus.s1_cmd;
                w_own_wr_data = bus.s1_wr_data;
            end
            default: begin
            end
        endcase
    end

    assign w_stop_done = bus.m_done && ((w_own_cmd & STOP_MASK) != 4'b0000);
    assign w_timeout   = !w_own_req && (r_idle_cnt == IDLE_TIMEOUT - 16'd1);

    always_comb begin
        w_state_next       = r_state;
        w_last_owner_next  = r_last_owner;
        w_idle_cnt_next    = '0;
        w_err_timeout_next = 1'b0;
        case (r_state)
            StIdle: begin
                // On a tie the requester that did not own the bus last wins.
                if (bus.s0_req && (!bus.s1_req || r_last_owner)) begin
                    w_state_next = StLock0;
                end else if (bus.s1_req) begin
                    w_state_next = StLock1;
                end
            end
            StLock0, StLock1: begin
                if (w_stop_done) begin
                    w_state_next      = StIdle;
                    w_last_owner_next = (r_state == StLock1);
                end else if (w_timeout) begin
                    w_state_next       = StIdle;
                    w_last_owner_next  = (r_state == StLock1);
                    w_err_timeout_next = 1'b1;
                end else if (!w_own_req) begin
                    w_idle_cnt_next = r_idle_cnt + 16'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_last_owner  <= 1'b1;
            r_idle_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_owner  <= w_last_owner_next;
            r_idle_cnt    <= w_idle_cnt_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    assign bus.m_req       = w_own_req;
    assign bus.m_cmd       = w_own_cmd;
    assign bus.m_wr_data   = w_own_wr_data;
    assign bus.s0_done     = (r_state == StLock0) && bus.m_done;
    assign bus.s1_done     = (r_state == StLock1) && bus.m_done;
    assign bus.s0_rd_data  = bus.m_rd_data;
    assign bus.s1_rd_data  = bus.m_rd_data;
    assign bus.gnt         = r_state;
    assign bus.busy        = |r_state;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus random traffic, each cycle checked against
// a transaction-level model of ownership, round-robin fairness and the silence watchdog.
module tb_i2c_bus_arbiter;
    localparam int         TO   = 16;
    localparam int         LAT  = 10;
    localparam logic [3:0] STOP = 4'b1000;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] wd;
        logic [7:0] gap;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    i2c_bus_arbiter_if bus ();

    i2c_bus_arbiter #(
        .STOP_MASK    (STOP),
        .IDLE_TIMEOUT (16'(TO))
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    item_t      q0[$];
    item_t      q1[$];
    item_t      cur[2];
    logic       cur_v[2];
    logic       rq[2];
    logic [3:0] cv[2];
    logic [7:0] wv[2];
    int         mdl_owner, mdl_last, mdl_quiet;
    logic       mdl_err;
    int         mcnt;
    logic       mdone;
    logic [7:0] mrd;
    logic [7:0] rd_src[$];
    logic       spur_en = 1'b0;
    int         dut_done[2];
    int         dut_err;
    int         exp_b[2];
    logic [7:0] rd_cap[$];
    int         grant_seq[$];
    int         gap_seq[$];
    int         idle_run;
    logic [1:0] prev_gnt;
    logic [7:0] rd_tab[7] = '{8'h1C, 8'h6B, 8'h5A, 8'h35, 8'hE2, 8'h71, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive();
        bus.s0_req     = rq[0];
        bus.s0_cmd     = cv[0];
        bus.s0_wr_data = wv[0];
        bus.s1_req     = rq[1];
        bus.s1_cmd     = cv[1];
        bus.s1_wr_data = wv[1];
        bus.m_done     = mdone;
        bus.m_rd_data  = mrd;
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_last  = 1;
        mdl_quiet = 0;
        mdl_err   = 1'b0;
        mcnt      = 0;
        mdone     = 1'b0;
        mrd       = 8'h00;
        q0.delete();
        q1.delete();
        rd_src.delete();
        for (int n = 0; n < 2; n++) begin
            cur_v[n] = 1'b0;
            rq[n]    = 1'b0;
            cv[n]    = 4'h0;
            wv[n]    = 8'h00;
        end
    endtask

    task automatic obs_clear();
        grant_seq.delete();
        gap_seq.delete();
        rd_cap.delete();
        idle_run    = 0;
        prev_gnt    = bus.gnt;
        dut_done[0] = 0;
        dut_done[1] = 0;
        dut_err     = 0;
        exp_b[0]    = 0;
        exp_b[1]    = 0;
    endtask

    task automatic push(input int n, input logic [3:0] c, input logic [7:0] d,
                        input logic [7:0] g);
        item_t it;
        it = '{cmd: c, wd: d, gap: g};
        if (n == 0) q0.push_back(it);
        else q1.push_back(it);
    endtask

    task automatic rand_txn(input int n, input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 7));
            if (i == len - 1) c = c | STOP;
            push(n, c, 8'($urandom), (i == 0) ? 8'(gap) : 8'd0);
        end
        exp_b[n] += len;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cycle();
        logic       exp_mreq;
        logic [3:0] exp_cmd;
        logic [7:0] exp_wd;
        logic [1:0] exp_gnt;
        logic [1:0] exp_done;
        for (int n = 0; n < 2; n++) begin
            if (!cur_v[n]) begin
                if (n == 0 && q0.size() > 0) begin
                    cur[n] = q0.pop_front();
                    cur_v[n] = 1'b1;
                end else if (n == 1 && q1.size() > 0) begin
                    cur[n] = q1.pop_front();
                    cur_v[n] = 1'b1;
                end
            end
            rq[n] = 1'b0;
            cv[n] = 4'h0;
            wv[n] = 8'h00;
            if (cur_v[n]) begin
                if (cur[n].gap != 8'd0) begin
                    cur[n].gap = cur[n].gap - 8'd1;
                end else begin
                    rq[n] = 1'b1;
                    cv[n] = cur[n].cmd;
                    wv[n] = cur[n].wd;
                end
            end
        end
        exp_mreq = (mdl_owner >= 0) ? rq[mdl_owner] : 1'b0;
        exp_cmd  = (mdl_owner >= 0) ? cv[mdl_owner] : 4'h0;
        exp_wd   = (mdl_owner >= 0) ? wv[mdl_owner] : 8'h00;
        exp_gnt  = (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
        mdone    = 1'b0;
        if (exp_mreq) begin
            mcnt++;
            if (mcnt == LAT) begin
                mdone = 1'b1;
                mcnt  = 0;
            end
        end else begin
            mcnt  = 0;
            mdone = (mdl_owner < 0) && spur_en && ($urandom_range(0, 7) == 0);
        end
        if (mdone && exp_mreq && rd_src.size() > 0) mrd = rd_src.pop_front();
        else mrd = 8'($urandom);
        exp_done = {(mdl_owner == 1) && mdone, (mdl_owner == 0) && mdone};
        drive();

        @(negedge clk);
        chk("gnt", bus.gnt, exp_gnt);
        chk("busy", bus.busy, |exp_gnt);
        chk("err_timeout", bus.err_timeout, mdl_err);
        chk("m_req", bus.m_req, exp_mreq);
        chk("m_cmd", bus.m_cmd, exp_cmd);
        chk("m_wr_data", bus.m_wr_data, exp_wd);
        chk("s0_done", bus.s0_done, exp_done[0]);
        chk("s1_done", bus.s1_done, exp_done[1]);
        chk("s0_rd_data", bus.s0_rd_data, mrd);
        chk("s1_rd_data", bus.s1_rd_data, mrd);
        if (bus.s0_done === 1'b1) dut_done[0]++;
        if (bus.s1_done === 1'b1) begin
            dut_done[1]++;
            rd_cap.push_back(bus.s1_rd_data);
        end
        if (bus.err_timeout === 1'b1) dut_err++;
        if (bus.gnt == 2'b00) begin
            idle_run++;
        end else if (prev_gnt == 2'b00) begin
            grant_seq.push_back((bus.gnt == 2'b10) ? 1 : 0);
            gap_seq.push_back(idle_run);
            idle_run = 0;
        end
        prev_gnt = bus.gnt;

        @(posedge clk);
        mdl_err = 1'b0;
        if (mdl_owner < 0) begin
            mdl_quiet = 0;
            if (rq[0] && rq[1]) mdl_owner = 1 - mdl_last;
            else if (rq[0]) mdl_owner = 0;
            else if (rq[1]) mdl_owner = 1;
        end else if (mdone && ((cv[mdl_owner] & STOP) != 4'h0)) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
            mdl_quiet = 0;
        end else if (!rq[mdl_owner]) begin
            mdl_quiet++;
            if (mdl_quiet >= TO) begin
                mdl_err   = 1'b1;
                mdl_last  = mdl_owner;
                mdl_owner = -1;
                mdl_quiet = 0;
            end
        end else begin
            mdl_quiet = 0;
        end
        for (int n = 0; n < 2; n++) if (exp_done[n]) cur_v[n] = 1'b0;
        #1;
    endtask

    task automatic run_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (!(!cur_v[0] && !cur_v[1] && q0.size() == 0 && q1.size() == 0 && mdl_owner < 0)
               && k < limit) begin
            cycle();
            k++;
        end
        chk({tag, "_finished"}, 32'(k < limit), 32'd1);
        repeat (3) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        drive();
        bus.s0_req = 1'b1;
        bus.s0_cmd = 4'hF;
        bus.m_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err_timeout, 1'b0);
        chk("rst_m_req", bus.m_req, 1'b0);
        chk("rst_m_cmd", bus.m_cmd, 4'h0);
        chk("rst_m_wr", bus.m_wr_data, 8'h00);
        chk("rst_s0_done", bus.s0_done, 1'b0);
        chk("rst_s1_done", bus.s1_done, 1'b0);
        drive();
        rst_n = 1'b1;

        // Simultaneous first requests: s0 wins the tie after reset.
        obs_clear();
        push(0, 4'b0011, 8'($urandom), 8'd0);
        push(0, 4'b1010, 8'($urandom), 8'd0);
        push(1, 4'b0011, 8'($urandom), 8'd0);
        push(1, 4'b1010, 8'($urandom), 8'd0);
        run_idle("tie", 200);
        chk("tie_ngrants", grant_seq.size(), 2);
        chk("tie_first", at(grant_seq, 0), 0);
        chk("tie_second", at(grant_seq, 1), 1);
        chk("tie_gap", at(gap_seq, 1), 1);
        chk("tie_s0_dones", dut_done[0], 2);
        chk("tie_s1_dones", dut_done[1], 2);

        // Single requester 4-byte write.
        obs_clear();
        push(0, 4'b0011, 8'($urandom), 8'd2);
        push(0, 4'b0010, 8'($urandom), 8'd0);
        push(0, 4'b0010, 8'($urandom), 8'd0);
        push(0, 4'b1010, 8'($urandom), 8'd0);
        run_idle("single", 200);
        chk("single_ngrants", grant_seq.size(), 1);
        chk("single_s0_dones", dut_done[0], 4);
        chk("single_s1_dones", dut_done[1], 0);

        // Round-robin with both requesters holding req: owners 0,1,0.
        obs_clear();
        push(0, 4'b0011, 8'($urandom), 8'd0);
        push(0, 4'b1010, 8'($urandom), 8'd0);
        push(0, 4'b0011, 8'($urandom), 8'd0);
        push(0, 4'b0010, 8'($urandom), 8'd0);
        push(0, 4'b1010, 8'($urandom), 8'd0);
        push(1, 4'b0011, 8'($urandom), 8'd2);
        push(1, 4'b1010, 8'($urandom), 8'd0);
        run_idle("rr", 400);
        chk("rr_ngrants", grant_seq.size(), 3);
        chk("rr_own0", at(grant_seq, 0), 0);
        chk("rr_own1", at(grant_seq, 1), 1);
        chk("rr_own2", at(grant_seq, 2), 0);
        chk("rr_gap1", at(gap_seq, 1), 1);
        chk("rr_gap2", at(gap_seq, 2), 1);

        // Read routing to s1.
        obs_clear();
        for (int i = 0; i < 7; i++) begin
            rd_src.push_back(rd_tab[i]);
            push(1, (i == 0) ? 4'b0101 : (i == 6) ? 4'b1100 : 4'b0100, 8'h00, 8'd0);
        end
        run_idle("read", 300);
        chk("read_count", rd_cap.size(), 7);
        for (int i = 0; i < 7; i++) chk("read_byte", (i < rd_cap.size()) ? rd_cap[i] : 8'hXX,
                                        rd_tab[i]);
        chk("read_s0_dones", dut_done[0], 0);

        // Watchdog: s0 goes silent after its first byte while s1 waits.
        obs_clear();
        push(0, 4'b0011, 8'($urandom), 8'd0);
        push(1, 4'b0011, 8'($urandom), 8'd5);
        push(1, 4'b1010, 8'($urandom), 8'd0);
        run_idle("wdog", 300);
        chk("wdog_err_pulses", dut_err, 1);
        chk("wdog_own0", at(grant_seq, 0), 0);
        chk("wdog_own1", at(grant_seq, 1), 1);
        chk("wdog_gap", at(gap_seq, 1), 1);
        chk("wdog_s0_dones", dut_done[0], 1);

        // Asynchronous reset in the middle of an s1 byte.
        obs_clear();
        push(1, 4'b0011, 8'($urandom), 8'd0);
        push(1, 4'b0010, 8'($urandom), 8'd0);
        push(1, 4'b1010, 8'($urandom), 8'd0);
        for (int k = 0; k < 20 && mdl_owner != 1; k++) cycle();
        repeat (4) cycle();
        chk("arst_pre_m_req", bus.m_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_req", bus.m_req, 1'b0);
        chk("arst_gnt", bus.gnt, 2'b00);
        chk("arst_busy", bus.busy, 1'b0);
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_clear();
        push(0, 4'b1011, 8'($urandom), 8'd0);
        push(1, 4'b1011, 8'($urandom), 8'd0);
        run_idle("arst_tie", 200);
        chk("arst_own0", at(grant_seq, 0), 0);
        chk("arst_own1", at(grant_seq, 1), 1);

        // Random traffic with spurious master dones while idle.
        obs_clear();
        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rand_txn(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                     int'($urandom_range(0, 12)));
        end
        run_idle("rand", 8000);
        chk("rand_s0_dones", dut_done[0], exp_b[0]);
        chk("rand_s1_dones", dut_done[1], exp_b[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
